obi_slave_responder: RTL
========================

Name: obi_slave_responder

Overview:
- Protocol-correct OBI slave responder that sits directly downstream of the core's instruction or data memory port in the formal/sim harness.
- One instance per port. It generates gnt and rvalid with a bounded number of in-order outstanding transactions and a minimum response latency.
- Unconstrained stall and read-data inputs stand in for the nondeterministic environment, so the core only ever sees legal OBI responses.
- It also checks the manager side: a request that is dropped or changed while ungranted raises a sticky flag.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..4).
- MIN_LATENCY, 1, minimum cycles from grant cycle to rvalid cycle (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  OBI request from core.
- gnt_o  out  1  OBI grant.
- addr_i  in  ADDR_WIDTH  request address.
- we_i  in  1  write enable (0 = read/fetch).
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_WIDTH  response data.
- gnt_stall_i  in  1  environment withholds grant this cycle.
- rvalid_stall_i  in  1  environment withholds response this cycle.
- rdata_src_i  in  DATA_WIDTH  free read data, used on read responses.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
- protocol_err_o  out  1  sticky manager-side protocol violation.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Queue empty, count 0, protocol_err_o 0, hold-tracking register cleared.
  - gnt_o 0, rvalid_o 0, rdata_o 0.
  - Reset mid-transaction discards all outstanding entries; no response is emitted for them.
- Grant (combinational):
  - gnt_o = req_i && !gnt_stall_i && (count < MAX_OUTSTANDING).
  - accept = req_i && gnt_o.
  - gnt_o never depends on a same-cycle pop: at count == MAX_OUTSTANDING, gnt_o = 0 even if rvalid_o = 1.
- Queue:
  - In-order FIFO of depth MAX_OUTSTANDING. Entry = {we, age}.
  - age is a saturating counter wide enough for MIN_LATENCY.
  - On accept, the entry is written with age 0.
  - Every cycle, each valid entry's age increments, saturating at MIN_LATENCY.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Response (combinational from head):
  - head_ready = !empty && head.age >= MIN_LATENCY-1.
  - rvalid_o = head_ready && !rvalid_stall_i. The pop occurs on that edge.
  - rdata_o = rdata_src_i for a read head; 0 for a write head, and 0 whenever rvalid_o = 0.
  - Earliest rvalid: with MIN_LATENCY = 1, a grant in cycle k gives rvalid in cycle k+1. Never in the grant cycle itself.
- Count:
  - accept only: +1. pop only: -1. Both in the same cycle: unchanged.
  - outstanding_o = count.
  - Overflow and underflow are structurally impossible; the implementation asserts this.
- Protocol check:
  - Register pend = req_i && !gnt_o, together with addr/we/be/wdata captured in that cycle.
  - If pend was set last cycle and this cycle has !req_i, or any captured field differs, set protocol_err_o.
  - protocol_err_o stays set until reset.
  - Responses continue normally after an error.
- Ordering: responses follow grant order strictly. Only the head is ever eligible.

Test Plan:
- Single read, no stalls, MIN_LATENCY = 1:
  - Stimulus: req_i = 1 with addr 0x1A000080 in cycle 0; rdata_src_i = 0xDEADBEEF in cycle 1.
  - Required: gnt_o = 1 in cycle 0; rvalid_o = 1 with rdata_o = 0xDEADBEEF in cycle 1; outstanding_o goes 0 -> 1 -> 0.
- Back-to-back requests with rvalid_stall_i held high, MAX_OUTSTANDING = 2:
  - Required: two grants in cycles 0 and 1; gnt_o = 0 in cycle 2 despite req_i = 1; outstanding_o = 2.
  - Release the stall in cycle 4: rvalid_o in cycles 4 and 5, in order; the third grant occurs only in cycle 5 (count is 1 after the cycle-4 pop).
- Simultaneous accept and pop at count 1:
  - Required: outstanding_o stays 1; the new entry responds in the following cycle.
- Write followed by read:
  - Stimulus: write (we_i = 1, be_i = 0xF) then read; rdata_src_i = 0x12345678.
  - Required: first rvalid shows rdata_o = 0; second shows 0x12345678.
- MIN_LATENCY = 3:
  - Stimulus: grant in cycle 0, no stalls.
  - Required: rvalid_o first high in cycle 3, not in cycles 1-2.
- Protocol violation:
  - Stimulus: req_i = 1 with gnt_stall_i = 1 in cycle 0; req_i drops in cycle 1.
  - Required: protocol_err_o = 1 from cycle 2 and stays set until rst_ni is asserted mid-run; rst_ni also clears outstanding_o to 0 and produces no pending rvalid.

Source files
------------

// File: rtl/obi_slave_responder.sv
// OBI slave responder: bounded in-order outstanding queue with a minimum
// response latency, plus a sticky checker for manager-side hold violations.
module obi_slave_responder #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int MIN_LATENCY     = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  gnt_stall_i,
  input  logic                  rvalid_stall_i,
  input  logic [DATA_WIDTH-1:0] rdata_src_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                  protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int AW = $clog2(MIN_LATENCY+1);
  localparam int BW = DATA_WIDTH/8;
  localparam logic [CW-1:0] MAXC    = CW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] AGE_MAX = AW'(MIN_LATENCY);
  localparam logic [AW:0]   LAT     = (AW+1)'(MIN_LATENCY);

  logic [MAX_OUTSTANDING-1:0] vld_q;
  logic [MAX_OUTSTANDING-1:0] we_q;
  logic [AW-1:0]              age_q [MAX_OUTSTANDING];
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [CW-1:0]              cnt_q;

  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  hwe_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;

  logic accept, pop, head_ready, viol;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  assign gnt_o  = rst_ni && req_i && !gnt_stall_i && (cnt_q < MAXC);
  assign accept = req_i && gnt_o;

  // age+1 >= MIN_LATENCY avoids a constant compare when MIN_LATENCY is 1
  assign head_ready = vld_q[rptr_q] &&
                      (({1'b0, age_q[rptr_q]} + 1'b1) >= LAT);
  assign rvalid_o = head_ready && !rvalid_stall_i;
  assign pop      = rvalid_o;
  assign rdata_o  = (rvalid_o && !we_q[rptr_q]) ? rdata_src_i : '0;

  assign outstanding_o  = cnt_q;
  assign protocol_err_o = err_q;

  assign viol = pend_q && (!req_i || addr_i != addr_q ||
                we_i != hwe_q || be_i != be_q || wdata_i != wdata_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      we_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (vld_q[i] && age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
      if (pop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= inc(rptr_q);
      end
      if (accept) begin
        vld_q[wptr_q] <= 1'b1;
        we_q[wptr_q]  <= we_i;
        age_q[wptr_q] <= '0;
        wptr_q        <= inc(wptr_q);
      end
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      hwe_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= req_i && !gnt_o;
      addr_q  <= addr_i;
      hwe_q   <= we_i;
      be_q    <= be_i;
      wdata_q <= wdata_i;
      err_q   <= err_q | viol;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni) begin
      assert (!(accept && !pop && cnt_q == MAXC));
      assert (!(pop && cnt_q == '0));
    end
  end

endmodule
